// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a one-hot grant and a valid/ready handshake.
//
// Requesters are scanned from ptr_q upwards, wrapping modulo NUM_REQ, so NUM_REQ does not
// have to be a power of two. A grant that is not accepted is captured in held_q and kept
// stable until the consumer takes it. Priority rotates only on a completed handshake.
//
// Build option: define RR_ARB_LOCK_EN to add the lock_i port and the LOCKED state. A locked
// handshake keeps re-granting the same requester for a burst. Without the macro, every
// handshake rotates priority.
//
// This file also holds the one-hot to binary encoder that produces gnt_idx_o.

// encoder: one-hot to binary index, with a valid flag when any bit is set.
module encoder #(
  parameter int unsigned NUM_WIRE = 4
) (
  input  logic [NUM_WIRE-1:0]         wire_in,
  output logic [$clog2(NUM_WIRE)-1:0] idx_o,
  output logic                        valid_o
);

  localparam int unsigned IdxW = $clog2(NUM_WIRE);

  // OR together the indices of set bits; exact for one-hot input, 0 for no input.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < NUM_WIRE; i++) begin
      if (wire_in[i]) begin
        idx_o = idx_o | IdxW'(i);
      end
    end
  end

  assign valid_o = |wire_in;

endmodule

module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic                       gnt_ready_i,
`ifdef RR_ARB_LOCK_EN
  input  logic                       lock_i,
`endif
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
  output logic                       gnt_valid_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);
  localparam logic [IdxW:0]   NumReqW = (IdxW + 1)'(NUM_REQ);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StHold   = 2'd1;
`ifdef RR_ARB_LOCK_EN
  localparam logic [1:0] StLocked = 2'd2;
`endif

  logic [1:0]         state_q, state_d;
  logic [IdxW-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0] held_q, held_d;

  logic [NUM_REQ-1:0] win_oh;
  logic [IdxW-1:0]    win_idx;
  logic               win_found;
  logic [IdxW:0]      scan_sum;
  logic [IdxW-1:0]    scan_pos;
  logic [IdxW-1:0]    held_idx;
  logic               handshake;
  logic               enc_valid;

  // Index one past idx, wrapping explicitly at NUM_REQ-1.
  function automatic logic [IdxW-1:0] next_ptr(input logic [IdxW-1:0] idx);
    return (idx == LastIdx) ? '0 : idx + 1'b1;
  endfunction

  // Round-robin scan: first set request at ptr_q, ptr_q+1, ... modulo NUM_REQ.
  always_comb begin
    win_oh    = '0;
    win_idx   = '0;
    win_found = 1'b0;
    scan_sum  = '0;
    scan_pos  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Both terms are below NUM_REQ, so one conditional subtract is a full modulo.
      scan_sum = {1'b0, ptr_q} + (IdxW + 1)'(i);
      if (scan_sum >= NumReqW) begin
        scan_sum = scan_sum - NumReqW;
      end
      scan_pos = scan_sum[IdxW-1:0];
      if (!win_found && req_i[scan_pos]) begin
        win_found         = 1'b1;
        win_oh[scan_pos]  = 1'b1;
        win_idx           = scan_pos;
      end
    end
  end

  // Binary index of the captured grant, needed to advance the pointer past it.
  always_comb begin
    held_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (held_q[i]) begin
        held_idx = IdxW'(i);
      end
    end
  end

  // Outputs depend on state, registers and req_i only; gnt_ready_i never reaches them.
  always_comb begin
    gnt_o       = '0;
    gnt_valid_o = 1'b0;
    if (!rst_i) begin
      case (state_q)
        StIdle: begin
          gnt_o       = win_oh;
          gnt_valid_o = win_found;
        end
        StHold: begin
          gnt_o       = held_q;
          gnt_valid_o = 1'b1;
        end
`ifdef RR_ARB_LOCK_EN
        StLocked: begin
          gnt_o       = held_q & req_i;
          gnt_valid_o = |(held_q & req_i);
        end
`endif
        default: begin
          gnt_o       = '0;
          gnt_valid_o = 1'b0;
        end
      endcase
    end
  end

  assign handshake = gnt_valid_o & gnt_ready_i;

  // Next-state: pointer rotation, grant capture on stall, and burst lock handling.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    held_d  = held_q;
    case (state_q)
      StIdle: begin
        if (handshake) begin
`ifdef RR_ARB_LOCK_EN
          if (lock_i) begin
            held_d  = win_oh;
            state_d = StLocked;
          end else begin
            ptr_d = next_ptr(win_idx);
          end
`else
          ptr_d = next_ptr(win_idx);
`endif
        end else if (gnt_valid_o) begin
          held_d  = win_oh;
          state_d = StHold;
        end
      end
      StHold: begin
        if (gnt_ready_i) begin
`ifdef RR_ARB_LOCK_EN
          if (lock_i) begin
            state_d = StLocked;
          end else begin
            ptr_d   = next_ptr(held_idx);
            state_d = StIdle;
          end
`else
          ptr_d   = next_ptr(held_idx);
          state_d = StIdle;
`endif
        end
      end
`ifdef RR_ARB_LOCK_EN
      StLocked: begin
        // Leave when the burst owner lets go, or on its final unlocked handshake.
        if (!gnt_valid_o || (gnt_ready_i && !lock_i)) begin
          ptr_d   = next_ptr(held_idx);
          state_d = StIdle;
        end
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset; a held grant is dropped with no rotation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      held_q  <= held_d;
    end
  end

  encoder #(
    .NUM_WIRE (NUM_REQ)
  ) u_encoder (
    .wire_in (gnt_o),
    .idx_o   (gnt_idx_o),
    .valid_o (enc_valid)
  );

  // The encoder's notion of "some grant" must agree with the arbiter's valid.
  enc_valid_matches: assert property (@(posedge clk_i) enc_valid == gnt_valid_o);

  // At most one grant bit is ever set.
  gnt_onehot: assert property (@(posedge clk_i) $onehot0(gnt_o));

  // The pointer always names a real requester.
  ptr_in_range: assert property (@(posedge clk_i) ptr_q <= LastIdx);

endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: directed checks of rr_arbiter with NUM_REQ=4 and NUM_REQ=3 instances.
// The lock scenario runs only when RR_ARB_LOCK_EN is defined.
module tb_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       rdy;
  logic       lock;
  logic [3:0] gnt;
  logic [1:0] idx;
  logic       vld;

  logic [2:0] req3;
  logic       rdy3;
  logic [2:0] gnt3;
  logic [1:0] idx3;
  logic       vld3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_arbiter #(
    .NUM_REQ (4)
  ) u_dut4 (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .gnt_ready_i (rdy),
`ifdef RR_ARB_LOCK_EN
    .lock_i      (lock),
`endif
    .gnt_o       (gnt),
    .gnt_idx_o   (idx),
    .gnt_valid_o (vld)
  );

  rr_arbiter #(
    .NUM_REQ (3)
  ) u_dut3 (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req3),
    .gnt_ready_i (rdy3),
`ifdef RR_ARB_LOCK_EN
    .lock_i      (1'b0),
`endif
    .gnt_o       (gnt3),
    .gnt_idx_o   (idx3),
    .gnt_valid_o (vld3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle on the 4-wide arbiter and check its outputs mid-cycle.
  task automatic step4(input string tag, input logic [3:0] r, input logic rd,
                       input logic [3:0] eg, input logic [1:0] ei, input logic ev);
    req = r;
    rdy = rd;
    @(negedge clk);
    check_eq({tag, ".gnt"}, 32'(gnt), 32'(eg));
    check_eq({tag, ".idx"}, 32'(idx), 32'(ei));
    check_eq({tag, ".vld"}, 32'(vld), 32'(ev));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] exp3_gnt [4];
    logic [1:0] exp3_idx [4];
    exp3_gnt = '{3'b001, 3'b100, 3'b001, 3'b100};
    exp3_idx = '{2'd0, 2'd2, 2'd0, 2'd2};

    rst  = 1'b1;
    req  = 4'b0000;
    rdy  = 1'b0;
    lock = 1'b0;
    req3 = 3'b000;
    rdy3 = 1'b0;
    @(posedge clk);
    #1;

    // Outputs forced low while reset is asserted, even with requests pending.
    req  = 4'b1111;
    rdy  = 1'b1;
    @(negedge clk);
    check_eq("rst.gnt", 32'(gnt), 32'h0);
    check_eq("rst.idx", 32'(idx), 32'h0);
    check_eq("rst.vld", 32'(vld), 32'h0);
    check_eq("rst.gnt3", 32'(gnt3), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Full rotation with every requester active.
    step4("rot0", 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1);
    step4("rot1", 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1);
    step4("rot2", 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1);
    step4("rot3", 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1);
    step4("rot4", 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1);

    // Stall: grant holds at 0010 while a new request appears; then wrap from ptr 2.
    step4("stall0", 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1);
    step4("stall1", 4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1);
    step4("stall2", 4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1);
    step4("stall3", 4'b0011, 1'b1, 4'b0010, 2'd1, 1'b1);
    step4("wrap",   4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1);

    // No request: nothing granted.
    step4("none", 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);

    // Stall on 1000, then reset in the middle of the hold.
    step4("hold8a", 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1);
    step4("hold8b", 4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("hrst.gnt", 32'(gnt), 32'h0);
    check_eq("hrst.idx", 32'(idx), 32'h0);
    check_eq("hrst.vld", 32'(vld), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step4("postrst", 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1);

    // Non-power-of-two wrap on the 3-wide instance.
    req  = 4'b0000;
    req3 = 3'b101;
    rdy3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq($sformatf("n3_%0d.gnt", i), 32'(gnt3), 32'(exp3_gnt[i]));
      check_eq($sformatf("n3_%0d.idx", i), 32'(idx3), 32'(exp3_idx[i]));
      @(posedge clk);
      #1;
    end
    req3 = 3'b000;

`ifdef RR_ARB_LOCK_EN
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    lock = 1'b1;
    step4("lock0", 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1);
    step4("lock1", 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1);
    step4("lock2", 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1);
    lock = 1'b0;
    step4("unlk0", 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1);
    step4("unlk1", 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter that picks one of `NUM_REQ` requesters per cycle and presents the winner as a one-hot grant vector with a valid/ready handshake. It sits directly upstream of the one-hot `encoder`: `gnt_o` drives the encoder's `wire_in`, and the encoded index is re-exported as `gnt_idx_o`. Typical uses are issue-slot, write-port and free-list selection in the core. Grants are held stable under back-pressure, and priority rotates only on a completed handshake.

## Interface
- `NUM_REQ`, 4: number of requesters; ≥2, need not be a power of 2.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `req_i`  in  `NUM_REQ`  request vector; any number of bits may be set.
- `gnt_o`  out  `NUM_REQ`  one-hot grant; all-zero when `gnt_valid_o`=0.
- `gnt_idx_o`  out  `$clog2(NUM_REQ)`  binary index of the set bit in `gnt_o`; 0 when no grant.
- `gnt_valid_o`  out  1  grant present.
- `gnt_ready_i`  in  1  consumer accepts the grant this cycle.
- `lock_i`  in  1  burst lock request; present only with `RR_ARB_LOCK_EN`.

## Operation
- State:
  - `ptr_q`: highest-priority requester index, range 0..`NUM_REQ`-1.
  - FSM with states `IDLE`, `HOLD`, `LOCKED`. `LOCKED` exists only with the macro.
  - `held_q`: one-hot register holding the captured grant.
- `IDLE`:
  - Winner is the first set bit of `req_i` scanning `ptr_q`, `ptr_q`+1, … with wrap-around modulo `NUM_REQ`.
  - `gnt_o` = winner combinationally; `gnt_valid_o` = `|req_i`.
- Handshake means `gnt_valid_o && gnt_ready_i` in the same cycle.
- On handshake with winner w: `ptr_q` ← (w+1) mod `NUM_REQ`. Compute the wrap explicitly, not by power-of-2 truncation. FSM stays in `IDLE`.
- Valid with no ready in `IDLE`:
  - `held_q` ← `gnt_o`; go to `HOLD`.
- `HOLD`:
  - `gnt_o` = `held_q`; `gnt_valid_o`=1 regardless of `req_i`. The grant never changes while stalled.
  - New or higher-priority requests are ignored.
  - On `gnt_ready_i`: pointer advances past the held index; go to `IDLE`.
- Requester contract: a requester keeps `req_i` high until it is granted. Dropping it while held is a protocol violation, and the arbiter still completes the held grant.
- `gnt_idx_o`: an internal `encoder #(.NUM_WIRE(NUM_REQ))` instance driven by `gnt_o`. The instance's valid output equals `gnt_valid_o`; assert this in simulation.
- Reset: `ptr_q`=0, `held_q`=0, FSM=`IDLE`. While `rst_i`=1, all outputs are forced to 0.
- Reset mid-`HOLD`: the held grant is discarded with no handshake counted, and `ptr_q` returns to 0.

## Timing
- Grant latency is 0 cycles: `req_i` → `gnt_o` is combinational in `IDLE`.
- `HOLD` outputs come from registers, one cycle after the stall.
- Pointer update takes effect the cycle after the handshake.
- Back-to-back handshakes every cycle are supported. Throughput is 1 grant/cycle.
- Fairness: with all requesters continuously active, each is granted once every `NUM_REQ` handshakes.
- No combinational path from `gnt_ready_i` to `gnt_o` or `gnt_valid_o`. `gnt_ready_i` only affects next-state.

## Configuration
- Macro: `RR_ARB_LOCK_EN`.
- Defined:
  - `lock_i` port exists.
  - A handshake with `lock_i`=1 does not advance `ptr_q` and enters `LOCKED`.
  - In `LOCKED`, `gnt_o` = `held_q` (the last winner) whenever that requester's `req_i` bit is high. `gnt_valid_o` follows that bit.
  - Leave `LOCKED` for `IDLE` on a handshake with `lock_i`=0 (pointer advances normally), or when the locked requester drops `req_i` (pointer advances past it).
  - Other requesters are blocked while `LOCKED`.
- Undefined: no `lock_i` port and no `LOCKED` state. Every handshake rotates priority.

## Test plan
- Reset, then `req_i`=4'b1111 with `gnt_ready_i`=1 for 5 cycles → `gnt_o` = 0001, 0010, 0100, 1000, 0001; `gnt_idx_o` = 0, 1, 2, 3, 0.
- `NUM_REQ`=3, `req_i`=3'b101, ready=1 for 4 cycles → grants 001, 100, 001, 100 (wrap with non-power-of-2).
- `req_i`=0010, ready=0 for 3 cycles while `req_i` changes to 0011 → `gnt_o` stays 0010, valid=1. Ready=1 → next `IDLE` grant is 0001, with `ptr_q`=2 scanning wrap.
- `req_i`=0000 → `gnt_valid_o`=0, `gnt_o`=0, `gnt_idx_o`=0. Asserting `rst_i` during `HOLD` on 1000 → next-cycle outputs 0 and the first grant afterwards starts from index 0.
- With `RR_ARB_LOCK_EN`: `req_i`=1111, `lock_i`=1 for 3 handshakes → 0001 three times. Then `lock_i`=0 → 0001 once more, then 0010.
